// File: rtl/uart_frame_decoder_pkg.sv
// Shared definitions for the UART frame decoder: FSM states, error codes and defaults.
package uart_frame_decoder_pkg;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_LEN_ZERO = 2'd1;
  localparam logic [1:0] ERR_CSUM     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0]  SYNC_DEFAULT    = 8'hA5;
  localparam int unsigned TIMEOUT_DEFAULT = 1000000;

endpackage

// File: rtl/uart_frame_decoder_timeout.sv
// Inter-byte timeout: loadable down-counter; expired_o after TIMEOUT_CYCLES enabled
// cycles since the last clear.
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/uart_frame_decoder.sv
// Parses SYNC/LEN/payload/CSUM frames popped from the UART receive FIFO and streams
// the payload as little-endian 32-bit words with per-frame ok/error status.
module uart_frame_decoder
  import uart_frame_decoder_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        receivable,
  input  logic [7:0]  recv_data,
  output logic        recv_flag,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic        word_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  state_e      state_q, state_d;
  logic        pop_q;
  logic [7:0]  words_left_q, words_left_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] word_data_q, word_data_d;
  logic        word_last_q, word_last_d;
  logic        word_valid_q, word_valid_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic tmo_expired, abort, pop;

  // A held word freezes the timeout, so backpressure can never abort a frame.
  assign abort = (state_q != ST_HUNT) && !word_valid_q && tmo_expired;
  assign pop   = !RST && receivable && !pop_q && !word_valid_q && !abort;

  uart_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (CLK),
    .rst      (RST),
    .clear_i  (pop || (state_q == ST_HUNT)),
    .enable_i ((state_q != ST_HUNT) && !word_valid_q),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    csum_d       = csum_q;
    word_data_d  = word_data_q;
    word_last_d  = word_last_q;
    word_valid_d = word_valid_q;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;

    if (abort) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      byte_idx_d  = '0;
      state_d     = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (pop && (recv_data == SYNC_BYTE)) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (pop) begin
            if (recv_data == 8'h00) begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_LEN_ZERO;
              state_d     = ST_HUNT;
            end else begin
              words_left_d = recv_data;
              csum_d       = recv_data;
              byte_idx_d   = '0;
              state_d      = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_valid_q) begin
            if (word_ready) begin
              word_valid_d = 1'b0;
              words_left_d = words_left_q - 8'd1;
              if (words_left_q == 8'd1) state_d = ST_CSUM;
            end
          end else if (pop) begin
            word_data_d[8*byte_idx_q +: 8] = recv_data;
            csum_d     = csum_q ^ recv_data;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              word_valid_d = 1'b1;
              word_last_d  = (words_left_q == 8'd1);
            end
          end
        end
        ST_CSUM: begin
          if (pop) begin
            if (recv_data == csum_q) begin
              frame_ok_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_CSUM;
            end
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_HUNT;
      pop_q        <= 1'b0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      csum_q       <= '0;
      word_data_q  <= '0;
      word_last_q  <= 1'b0;
      word_valid_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      pop_q        <= pop;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
      csum_q       <= csum_d;
      word_data_q  <= word_data_d;
      word_last_q  <= word_last_d;
      word_valid_q <= word_valid_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign recv_flag  = pop;
  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign word_last  = word_last_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: a byte-queue FIFO model feeds the DUT and a
// frame-level parser predicts the word/status event stream checked by a monitor.
module tb_uart_frame_decoder;

  localparam int unsigned TO = 100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        receivable = 1'b0;
  logic [7:0]  recv_data = 8'h00;
  logic        recv_flag;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [31:0] word_data;
  logic        word_last;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;

  always #5 CLK = ~CLK;

  uart_frame_decoder #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .receivable(receivable),
    .recv_data (recv_data),
    .recv_flag (recv_flag),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data (word_data),
    .word_last (word_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          kind;   // 0 word, 1 frame ok, 2 frame error
    logic [31:0] data;
    logic        last;
    logic [1:0]  code;
  } ev_t;

  bq_t  fifo;
  ev_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;
  int   ready_mode = 0;  // 0 random, 1 hold low, 2 hold high
  logic flag_s = 1'b0;
  logic prev_flag = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Frame-level reference: walks the byte stream and lists the events it must produce.
  task automatic model(input bq_t b);
    int unsigned i = 0;
    logic [7:0]  len, cs;
    ev_t e;
    while (i < b.size()) begin
      if (b[i] != 8'hA5) begin
        i++;
      end else begin
        len = b[i+1];
        i += 2;
        if (len == 8'h00) begin
          e = '{kind: 2, data: '0, last: 1'b0, code: 2'd1};
          exp_q.push_back(e);
        end else begin
          cs = len;
          for (int unsigned w = 0; w < len; w++) begin
            e = '{kind: 0, data: {b[i+3], b[i+2], b[i+1], b[i]}, last: (w == len - 1), code: 2'd0};
            cs = cs ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
            exp_q.push_back(e);
            i += 4;
          end
          if (b[i] == cs) e = '{kind: 1, data: '0, last: 1'b0, code: 2'd0};
          else            e = '{kind: 2, data: '0, last: 1'b0, code: 2'd2};
          exp_q.push_back(e);
          i++;
        end
      end
    end
  endtask

  task automatic send(input bq_t b);
    foreach (b[k]) fifo.push_back(b[k]);
    model(b);
  endtask

  task automatic mk_frame(input int unsigned len, input bit bad, output bq_t f);
    logic [7:0] cs, v;
    f = {};
    f.push_back(8'hA5);
    f.push_back(8'(len));
    cs = 8'(len);
    for (int unsigned k = 0; k < 4 * len; k++) begin
      v = 8'($urandom);
      cs ^= v;
      f.push_back(v);
    end
    if (bad) cs ^= 8'($urandom_range(1, 255));
    f.push_back(cs);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || word_valid) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL idle_wait: %0d bytes and %0d events still pending, expected 0",
               fifo.size(), exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!word_valid && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("word_valid_wait", {31'd0, word_valid}, 64'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {word_valid, word_last, word_data, frame_ok, frame_err, err_code}, 64'd0);
  endtask

  // FIFO and word_ready driver
  initial forever begin
    @(posedge CLK);
    if (flag_s && fifo.size() != 0) void'(fifo.pop_front());
    #1;
    receivable = (fifo.size() != 0);
    recv_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    case (ready_mode)
      0:       word_ready = 1'($urandom_range(0, 1));
      1:       word_ready = 1'b0;
      default: word_ready = 1'b1;
    endcase
  end

  // Monitor
  initial forever begin
    ev_t e;
    int  gap;
    @(negedge CLK);
    cyc++;
    flag_s = recv_flag;
    if (RST) begin
      chk("flag_in_reset", {63'd0, recv_flag}, 64'd0);
      prev_flag  = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (recv_flag) begin
        chk("pop_rule", {61'd0, prev_flag, receivable, word_valid}, 64'b010);
        last_pop_cyc = cyc;
      end
      if (word_valid && !prev_valid) chk("valid_latency", {63'd0, prev_flag}, 64'd1);
      if (prev_valid && !prev_ready)
        chk("hold_stable", {30'd0, word_valid, word_last, word_data}, {30'd0, 1'b1, prev_last, prev_data});
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", {32'd0, word_data}, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("word", {29'd0, 2'd0, word_last, word_data}, {29'd0, e.kind[1:0], e.last, e.data});
        end
      end
      if (frame_ok || frame_err) chk("ok_err_exclusive", {63'd0, frame_ok & frame_err}, 64'd0);
      if (frame_ok) begin
        if (exp_q.size() == 0) chk("unexpected_ok", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("frame_ok", 64'd1, 64'(e.kind));
        end
      end
      if (frame_err) begin
        if (exp_q.size() == 0) chk("unexpected_err", {62'd0, err_code}, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("frame_err", {60'd0, 2'd2, err_code}, {60'd0, e.kind[1:0], e.code});
          if (err_code == 2'd3) begin
            gap = cyc - last_pop_cyc;
            tests++;
            if (gap < int'(TO) || gap > int'(TO) + 2) begin
              fails++;
              $display("FAIL timeout_gap: got %0d cycles, expected %0d..%0d", gap, TO, TO + 2);
            end
          end
        end
      end
      prev_flag  = recv_flag;
      prev_valid = word_valid;
      prev_ready = word_ready;
      prev_last  = word_last;
      prev_data  = word_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    bq_t b, f;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk_zero("reset_outputs");

    ready_mode = 2;
    send({8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45});
    wait_idle(500);

    ready_mode = 0;
    mk_frame(2, 1'b0, f);
    b = {8'h00, 8'hFF, 8'h5A};
    send({b, f});
    wait_idle(500);

    send({8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00});
    wait_idle(500);
    chk("err_code_hold", {62'd0, err_code}, 64'd2);

    mk_frame(1, 1'b0, f);
    b = {8'hA5, 8'h00};
    send({b, f});
    wait_idle(500);

    send({8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01});
    wait_idle(500);

    // backpressure longer than the timeout with bytes waiting in the FIFO
    ready_mode = 1;
    mk_frame(3, 1'b0, f);
    send(f);
    wait_valid(100);
    repeat (150) @(negedge CLK);
    chk("bp_fifo_level", 64'(fifo.size()), 64'd9);
    chk("bp_pending_events", 64'(exp_q.size()), 64'd4);
    ready_mode = 0;
    wait_idle(500);

    for (int n = 0; n < 30; n++) begin
      b = {};
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) b.push_back(8'($urandom_range(0, 8'hA4)));
      if ($urandom_range(0, 7) == 0) f = {8'hA5, 8'h00};
      else mk_frame($urandom_range(1, 6), $urandom_range(0, 3) == 0, f);
      send({b, f});
      wait_idle(3000);
    end

    ready_mode = 2;
    mk_frame(255, 1'b0, f);
    send(f);
    wait_idle(5000);

    ready_mode = 0;
    fifo = {8'hA5, 8'h02, 8'h11, 8'h22};
    exp_q.push_back('{kind: 2, data: '0, last: 1'b0, code: 2'd3});
    wait_idle(1000);

    // reset while a word is held mid-frame
    ready_mode = 1;
    fifo = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    wait_valid(100);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    fifo.delete();
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk_zero("mid_frame_reset");
    ready_mode = 0;
    repeat (5) @(negedge CLK);
    mk_frame(2, 1'b0, f);
    send(f);
    wait_idle(500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
